seg_scan_driver: RTL and testbench

Parametrised time-multiplexed seven-segment display driver, successor to the fixed six-digit select scanner. Generates its own scan rate from `sys_clk` with a clock-enable prescaler instead of a PLL-derived clock. Adds hex segment decode, decimal points, per-digit enable with skipping, inter-digit ghost blanking and tear-free frame-synchronous data updates. Sits between the host register/data path and the board's digit-select and segment pins.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_hex_decode.sv | 16 +
 rtl/seg_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and hex-to-seven-segment table for the scan driver.
// Patterns are active-high; polarity is applied at the output registers.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to active-high segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    always_comb begin
        pattern                = SEG_BLANK;
        pattern[SEG_G:SEG_A]   = hex_to_seg(nibble);
        pattern[SEG_DP]        = dp;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with prescaled stepping, digit skipping,
// ghost blanking and frame-synchronous commit of shadowed display data.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS     = 6,
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLANK_CYC  = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int   DIV   = CLK_HZ / SCAN_HZ;
    localparam int   PRE_W = $clog2(DIV);
    localparam int   IDX_W = $clog2(DIGITS);
    localparam int   BLK_W = $clog2(BLANK_CYC + 2);
    localparam logic POL_N = (ACTIVE_LOW != 0);

    logic [PRE_W-1:0]    pre_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLK_W-1:0]    blank_q, blank_d;
    logic                live_q, live_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] pend_data_q, act_data_q, data_c;
    logic [DIGITS-1:0]   pend_dp_q, act_dp_q, dp_c;
    logic [DIGITS-1:0]   pend_en_q, act_en_q, en_c;

    logic                tick, boundary;
    logic                higher_found, low_found;
    logic [IDX_W-1:0]    higher_idx, low_idx;
    logic                show;
    logic [3:0]          nibble;
    logic                dp_bit;
    logic [7:0]          pattern;
    logic [DIGITS-1:0]   sel_hi;
    logic [7:0]          seg_hi;

    assign tick = (pre_q == PRE_W'(DIV - 1));

    // A tick with no enabled digit above idx wraps the scan: that is the frame boundary.
    always_comb begin
        higher_found = 1'b0;
        higher_idx   = idx_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (!higher_found && k > int'(idx_q) && act_en_q[k]) begin
                higher_found = 1'b1;
                higher_idx   = IDX_W'(k);
            end
        end
        boundary = tick && !higher_found;
    end

    // load is a single-cycle strobe with no backpressure: whatever is on data/dp/digit_en
    // while it is high is taken on that edge, committed directly if the edge is a boundary.
    always_comb begin
        data_c = act_data_q;
        dp_c   = act_dp_q;
        en_c   = act_en_q;
        if (boundary) begin
            if (load) begin
                data_c = data;
                dp_c   = dp;
                en_c   = digit_en;
            end else if (pend_q) begin
                data_c = pend_data_q;
                dp_c   = pend_dp_q;
                en_c   = pend_en_q;
            end
        end
        pend_d = boundary ? 1'b0 : (load | pend_q);
    end

    always_comb begin
        low_found = 1'b0;
        low_idx   = idx_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (!low_found && en_c[k]) begin
                low_found = 1'b1;
                low_idx   = IDX_W'(k);
            end
        end
        idx_d = idx_q;
        if (tick) begin
            if (higher_found) begin
                idx_d = higher_idx;
            end else if (low_found) begin
                idx_d = low_idx;
            end
        end
        if (tick) begin
            blank_d = BLK_W'(BLANK_CYC);
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end else begin
            blank_d = '0;
        end
        live_d = live_q | tick;
        show   = live_d && (blank_d == '0) && (en_c != '0);
    end

    always_comb begin
        nibble = 4'h0;
        dp_bit = 1'b0;
        sel_hi = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nibble    = data_c[4*k +: 4];
                dp_bit    = dp_c[k];
                sel_hi[k] = show;
            end
        end
    end

    seg_hex_decode u_dec (
        .nibble  (nibble),
        .dp      (dp_bit),
        .pattern (pattern)
    );

    assign seg_hi = show ? pattern : SEG_BLANK;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_q       <= '0;
            idx_q       <= IDX_W'(DIGITS - 1);
            blank_q     <= '0;
            live_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_en_q   <= '1;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '1;
            sel         <= POL_N ? '1 : '0;
            seg         <= POL_N ? ~SEG_BLANK : SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            pre_q       <= tick ? '0 : pre_q + 1'b1;
            idx_q       <= idx_d;
            blank_q     <= blank_d;
            live_q      <= live_d;
            pend_q      <= pend_d;
            if (load && !boundary) begin
                pend_data_q <= data;
                pend_dp_q   <= dp;
                pend_en_q   <= digit_en;
            end
            act_data_q  <= data_c;
            act_dp_q    <= dp_c;
            act_en_q    <= en_c;
            sel         <= POL_N ? ~sel_hi : sel_hi;
            seg         <= POL_N ? ~seg_hi : seg_hi;
            frame_start <= boundary && low_found;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios with literal expectations plus
// randomized loads/resets checked every cycle against a time-based display model.
module tb_seg_scan_driver;

    localparam int DIGITS    = 6;
    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int BLANK_CYC = 2;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic [4*DIGITS-1:0] data = '0;
    logic [DIGITS-1:0]   dp = '0;
    logic [DIGITS-1:0]   digit_en = '1;
    logic                load = 1'b0;
    logic [DIGITS-1:0]   sel;
    logic [7:0]          seg;
    logic                frame_start;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(
        .DIGITS     (DIGITS),
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .BLANK_CYC  (BLANK_CYC),
        .ACTIVE_LOW (1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .data        (data),
        .dp          (dp),
        .digit_en    (digit_en),
        .load        (load),
        .sel         (sel),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned hex7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    bit                  m_valid = 0;
    int                  m_t, m_last_tick, m_idx;
    bit                  m_live, m_pend, m_tick, m_bound;
    logic [4*DIGITS-1:0] m_data, p_data;
    logic [DIGITS-1:0]   m_dp, p_dp, m_en, p_en;
    logic [DIGITS-1:0]   e_sel;
    logic [7:0]          e_seg;
    logic                e_frame;
    logic [3:0]          m_nib;
    int                  m_higher, m_lowest;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_valid = 1; m_t = 0; m_last_tick = 0; m_idx = DIGITS - 1;
            m_live = 0; m_pend = 0; m_data = '0; m_dp = '0; m_en = '1;
            e_frame = 0;
        end else begin
            m_t++;
            e_frame = 0;
            m_tick  = (m_t % DIV == 0);
            m_bound = 0;
            if (m_tick) begin
                m_higher = -1;
                for (int i = m_idx + 1; i < DIGITS; i++)
                    if (m_en[i] && m_higher < 0) m_higher = i;
                if (m_higher >= 0) begin
                    m_idx = m_higher;
                end else begin
                    m_bound = 1;
                    if (load) begin
                        m_data = data; m_dp = dp; m_en = digit_en; m_pend = 0;
                    end else if (m_pend) begin
                        m_data = p_data; m_dp = p_dp; m_en = p_en; m_pend = 0;
                    end
                    m_lowest = -1;
                    for (int i = 0; i < DIGITS; i++)
                        if (m_en[i] && m_lowest < 0) m_lowest = i;
                    if (m_lowest >= 0) begin
                        m_idx = m_lowest;
                        e_frame = 1;
                    end
                end
                m_last_tick = m_t;
                m_live = 1;
            end
            if (load && !m_bound) begin
                p_data = data; p_dp = dp; p_en = digit_en; m_pend = 1;
            end
        end
        if (m_live && (m_t - m_last_tick) >= BLANK_CYC && m_en != '0) begin
            m_nib = 4'((m_data >> (4 * m_idx)) & 24'hF);
            e_sel = ~(6'b000001 << m_idx);
            e_seg = ~{m_dp[m_idx], hex7[m_nib][6:0]};
        end else begin
            e_sel = '1;
            e_seg = 8'hFF;
        end
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("model_sel", sel, e_sel);
            chk("model_seg", seg, e_seg);
            chk("model_frame_start", frame_start, e_frame);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] e);
        data = d; dp = p; digit_en = e; load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    task automatic wait_sel(input logic [5:0] s, input int budget, input string name);
        int n = 0;
        while (sel !== s && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk(name, sel, s);
    endtask

    task automatic wait_frame(input int budget, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (frame_start !== 1'b1 && n < budget);
        chk("frame_seen", frame_start, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    byte unsigned exp_full [6] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    logic [5:0] one_hot_n;
    int period, bad;

    initial begin
        cyc(3);
        chk("rst_sel", sel, 6'h3F);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_frame", frame_start, 1'b0);

        // release and load 0x543210 on edge 1; it commits at the first boundary (edge 10)
        sys_rst = 1'b0;
        pulse_load(24'h543210, 6'h00, 6'h3F);
        cyc(9);
        chk("first_frame_edge10", frame_start, 1'b1);
        chk("first_tick_blank", sel, 6'h3F);
        cyc(2);
        chk("edge12_sel", sel, 6'h3E);
        chk("edge12_seg", seg, 8'hC0);
        for (int k = 1; k < DIGITS; k++) begin
            cyc(8);
            chk("scan_blank_sel", sel, 6'h3F);
            chk("scan_blank_seg", seg, 8'hFF);
            cyc(2);
            one_hot_n = ~(6'b000001 << k);
            chk("scan_sel", sel, one_hot_n);
            chk("scan_seg", seg, exp_full[k]);
        end

        // tear-free update while digit 2 is shown
        wait_sel(6'h3B, 80, "wait_digit2");
        pulse_load(24'hFFFFFF, 6'b000001, 6'h3F);
        wait_sel(6'h37, 30, "wait_digit3");
        chk("old_digit3", seg, 8'hB0);
        wait_sel(6'h2F, 30, "wait_digit4");
        chk("old_digit4", seg, 8'h99);
        wait_sel(6'h1F, 30, "wait_digit5");
        chk("old_digit5", seg, 8'h92);
        wait_sel(6'h3E, 30, "wait_new_digit0");
        chk("new_digit0_dp", seg, 8'h0E);
        wait_sel(6'h3D, 30, "wait_new_digit1");
        chk("new_digit1", seg, 8'h8E);

        // skipping: only 0, 2, 5
        pulse_load(24'h543210, 6'h00, 6'b100101);
        wait_frame(80, period);
        wait_sel(6'h3B, 30, "skip_digit2");
        chk("skip_digit2_seg", seg, 8'hA4);
        wait_frame(80, period);
        period = period + 0;
        wait_frame(80, period);
        chk("skip_frame_period", period, 30);

        // empty enable
        pulse_load(24'h543210, 6'h00, 6'h00);
        cyc(40);
        bad = 0;
        for (int k = 0; k < 35; k++) begin
            if (frame_start !== 1'b0 || sel !== 6'h3F || seg !== 8'hFF) bad++;
            @(negedge sys_clk);
        end
        chk("empty_quiet_cycles", bad, 0);
        pulse_load(24'h543210, 6'h00, 6'h3F);
        wait_sel(6'h3E, DIV + BLANK_CYC + 1, "resume_digit0");
        chk("resume_seg", seg, 8'hC0);

        // reset mid-scan with a load pending
        wait_sel(6'h37, 80, "wait_digit3_rst");
        pulse_load(24'h111111, 6'h3F, 6'h3F);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst_sel", sel, 6'h3F);
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_frame", frame_start, 1'b0);
        sys_rst = 1'b0;
        cyc(12);
        chk("post_rst_sel", sel, 6'h3E);
        chk("post_rst_seg", seg, 8'hC0);

        // randomized loads and occasional resets, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 14) == 0) begin
                data     = 24'($urandom);
                dp       = 6'($urandom_range(0, 63));
                digit_en = ($urandom_range(0, 7) == 0) ? 6'h00 : 6'($urandom_range(0, 63));
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            sys_rst = ($urandom_range(0, 499) == 0);
            @(negedge sys_clk);
        end
        load = 1'b0;
        sys_rst = 1'b0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
